// File: rtl/crc_serial_tx.sv
// Serial frame transmitter: shifts a latched word out MSB-first on each Tick, then appends its CRC.
// Optional build macro CRC_XOROUT_EN inverts the final CRC before it is reported and transmitted.
module crc_serial_tx #(
  parameter int DATA_W = 16,
  parameter int CRC_W  = 8,
  parameter logic [CRC_W-1:0] POLY = 8'h07,
  parameter logic [CRC_W-1:0] INIT = 8'h00
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Tick,
  input  logic              Start,
  input  logic [DATA_W-1:0] Data_In,
  output logic              Busy,
  output logic              Tx_Bit,
  output logic              Tx_Valid,
  output logic              Done,
  output logic [CRC_W-1:0]  Crc_Out,
  output logic [1:0]        State_Dbg
);

  localparam int MAX_W = (DATA_W > CRC_W) ? DATA_W : CRC_W;
  localparam int CNT_W = $clog2(MAX_W) + 1;
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);

`ifdef CRC_XOROUT_EN
  localparam logic [CRC_W-1:0] XOROUT = '1;
`else
  localparam logic [CRC_W-1:0] XOROUT = '0;
`endif

  // State_Dbg mirrors this encoding; IDLE reads as 0.
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_CRC, S_LAST} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [CRC_W-1:0]    crc_q, crc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                tx_bit_q, tx_bit_d;
  logic                tx_valid_q, tx_valid_d;
  logic                done_q, done_d;
  logic [CRC_W-1:0]    crc_out_q, crc_out_d;
  logic [CRC_W-1:0]    crc_step;

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    crc_out_d  = crc_out_q;
    crc_step   = {crc_q[CRC_W-2:0], 1'b0} ^
                 ((sh_q[DATA_W-1] ^ crc_q[CRC_W-1]) ? POLY : '0);

    case (state_q)
      S_IDLE: begin
        // A Tick coinciding with Start is deliberately not a bit period of this frame.
        if (Start) begin
          sh_d    = Data_In;
          crc_d   = INIT;
          cnt_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (Tick) begin
          tx_bit_d   = sh_q[DATA_W-1];
          tx_valid_d = 1'b1;
          sh_d       = {sh_q[DATA_W-2:0], 1'b0};
          if (cnt_q == DATA_LAST) begin
            crc_d     = crc_step ^ XOROUT;
            crc_out_d = crc_step ^ XOROUT;
            cnt_d     = '0;
            state_d   = S_CRC;
          end else begin
            crc_d = crc_step;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_CRC: begin
        if (Tick) begin
          tx_bit_d = crc_q[CRC_W-1];
          crc_d    = {crc_q[CRC_W-2:0], 1'b0};
          if (cnt_q == CRC_LAST) begin
            cnt_d   = '0;
            state_d = S_LAST;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_LAST: begin
        if (Tick) begin
          tx_bit_d   = 1'b0;
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      crc_q      <= '0;
      cnt_q      <= '0;
      tx_bit_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      crc_out_q  <= '0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
      crc_out_q  <= crc_out_d;
    end
  end

  assign Busy      = (state_q != S_IDLE);
  assign Tx_Bit    = tx_bit_q;
  assign Tx_Valid  = tx_valid_q;
  assign Done      = done_q;
  assign Crc_Out   = crc_out_q;
  assign State_Dbg = state_q;

endmodule

// File: tb/tb_crc_serial_tx.sv
// Randomized bench for crc_serial_tx: a frame-level model predicts every line bit, Done and Crc_Out.
// Inputs change on the falling edge; the model samples them on the rising edge.
module tb_crc_serial_tx;

  localparam int DATA_W = 16;
  localparam int CRC_W  = 8;
  localparam logic [CRC_W-1:0] POLY = 8'h07;
  localparam logic [CRC_W-1:0] INIT = 8'h00;
`ifdef CRC_XOROUT_EN
  localparam logic [CRC_W-1:0] XOROUT = 8'hFF;
`else
  localparam logic [CRC_W-1:0] XOROUT = 8'h00;
`endif

  logic              Clk, Reset, Tick, Start;
  logic [DATA_W-1:0] Data_In;
  logic              Busy, Tx_Bit, Tx_Valid, Done;
  logic [CRC_W-1:0]  Crc_Out;
  logic [1:0]        State_Dbg;

  crc_serial_tx dut (
    .Clk(Clk), .Reset(Reset), .Tick(Tick), .Start(Start), .Data_In(Data_In),
    .Busy(Busy), .Tx_Bit(Tx_Bit), .Tx_Valid(Tx_Valid), .Done(Done),
    .Crc_Out(Crc_Out), .State_Dbg(State_Dbg)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int frames_done = 0;
  int cyc = 0;
  int tick_mode = 0;   // 0 off, 1 held high, 2 every tick_per clocks, 3 random
  int tick_per = 1;
  bit lat_chk = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // CRC as the remainder of polynomial long division of the message by x^CRC_W + POLY.
  function automatic logic [CRC_W-1:0] ref_crc(input logic [DATA_W-1:0] d);
    logic [63:0] m;
    logic [63:0] g;
    m = (64'(d) << CRC_W) ^ (64'(INIT) << DATA_W);
    g = (64'(1) << CRC_W) | 64'(POLY);
    for (int i = DATA_W + CRC_W - 1; i >= CRC_W; i--)
      if (m[i]) m = m ^ (g << (i - CRC_W));
    return m[CRC_W-1:0];
  endfunction

  logic [0:0]       exp_q[$];
  logic [CRC_W-1:0] m_crc = '0;
  bit               m_busy = 0;
  bit               m_valid = 0;
  logic             last_bit = 1'b0;
  int               start_cyc = 0;

  task automatic model_accept(input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    c = ref_crc(d) ^ XOROUT;
    for (int i = DATA_W - 1; i >= 0; i--) exp_q.push_back(d[i]);
    for (int i = CRC_W - 1; i >= 0; i--) exp_q.push_back(c[i]);
    m_crc     = c;
    m_busy    = 1;
    start_cyc = cyc;
  endtask

  // ---------------- tick driver ----------------
  initial begin
    int cnt = 0;
    Tick = 1'b0;
    forever begin
      @(negedge Clk);
      case (tick_mode)
        0: Tick = 1'b0;
        1: Tick = 1'b1;
        2: begin
          cnt++;
          if (cnt >= tick_per) begin cnt = 0; Tick = 1'b1; end
          else Tick = 1'b0;
        end
        default: Tick = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    bit ev_tick;
    logic [0:0] b;
    forever begin
      @(posedge Clk);
      cyc++;
      ev_tick = 0;
      if (!Reset) begin
        exp_q.delete();
        m_busy = 0; m_valid = 0; last_bit = 1'b0;
        continue;
      end
      if (!m_busy) begin
        if (Start) model_accept(Data_In);
      end else if (Tick) begin
        ev_tick = 1;
      end
      @(negedge Clk);
      if (!Reset) continue;
      if (ev_tick && exp_q.size() > 0) begin
        b = exp_q.pop_front();
        m_valid = 1;
        last_bit = b;
        check("line_bit", Tx_Bit, b);
        check("line_valid", Tx_Valid, 1);
        check("done_mid", Done, 0);
      end else if (ev_tick) begin
        m_busy = 0; m_valid = 0; last_bit = 1'b0;
        check("done_pulse", Done, 1);
        check("end_valid", Tx_Valid, 0);
        check("end_bit", Tx_Bit, 0);
        check("crc_out", Crc_Out, m_crc);
        if (lat_chk) check("done_latency", cyc - start_cyc, DATA_W + CRC_W + 1);
        frames_done++;
      end else begin
        check("done_idle", Done, 0);
        check("bit_hold", Tx_Bit, last_bit);
        check("valid_hold", Tx_Valid, m_valid);
      end
      check("busy", Busy, m_busy);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(posedge Clk);
      n++;
    end
    check("frame_wait", frames_done, target);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d);
    @(negedge Clk);
    Start = 1'b1;
    Data_In = d;
    @(negedge Clk);
    Start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset = 1'b0; Start = 1'b0; Data_In = '0;
    repeat (3) @(negedge Clk);
    check("rst_busy", Busy, 0);
    check("rst_bit", Tx_Bit, 0);
    check("rst_valid", Tx_Valid, 0);
    check("rst_done", Done, 0);
    check("rst_crc", Crc_Out, 0);
    check("rst_state", State_Dbg, 0);
    Reset = 1'b1;

    // Tick held high, Tick coincident with Start: 25 clocks to Done.
    tick_mode = 1;
    lat_chk = 1;
    send_frame(16'h0001);
    wait_frames(1, 100);
    lat_chk = 0;
    check("crc_0001", Crc_Out, 8'h07 ^ XOROUT);

    // Slow tick: each bit held 20 clocks.
    tick_mode = 2; tick_per = 20;
    send_frame(16'h0100);
    wait_frames(2, 30 * 20);
    check("crc_0100", Crc_Out, 8'h15 ^ XOROUT);

    // Async reset in the middle of the data phase aborts the frame.
    tick_mode = 1;
    send_frame(16'hA5C3);
    repeat (6) @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("abort_busy", Busy, 0);
    check("abort_bit", Tx_Bit, 0);
    check("abort_valid", Tx_Valid, 0);
    check("abort_done", Done, 0);
    check("abort_crc", Crc_Out, 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    repeat (6) @(negedge Clk);
    check("idle_after_abort", Busy, 0);

    // Start held high: first word captured, second frame starts in the Done cycle.
    @(negedge Clk);
    Start = 1'b1; Data_In = 16'h1234;
    repeat (6) @(negedge Clk);
    Data_In = 16'hBEEF;
    wait_frames(3, 100);
    @(negedge Clk);
    Start = 1'b0; Data_In = 16'h0F0F;
    wait_frames(4, 100);
    check("crc_beef", Crc_Out, ref_crc(16'hBEEF) ^ XOROUT);

    // Randomized frames with varied tick patterns and an ignored mid-frame Start.
    for (int f = 0; f < 8; f++) begin
      tick_mode = $urandom_range(1, 3);
      tick_per = $urandom_range(2, 5);
      send_frame(16'($urandom));
      repeat ($urandom_range(2, 10)) @(negedge Clk);
      send_frame(16'($urandom));
      wait_frames(5 + f, 3000);
    end

    tick_mode = 0;
    repeat (4) @(negedge Clk);
    check("exp_q_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
